// File: rtl/mmm_serial_core.sv
// rtl/mmm_serial_core.sv - bit-serial radix-2 Montgomery modular multiplier
//
// Computes p_out = a_in * b_in * 2^-(WIDTH+2) mod m_in, one iteration per
// enabled clock. No final subtraction, so the result is < 2*m_in.
//
// Ports:
//   clk      rising-edge clock
//   rstb     synchronous active-low reset, overrides everything incl. ena
//   ena      clock enable; all state holds when low
//   rst_mmm  synchronous active-low clear of multiplier state (not p_out)
//   ld_a     load operands and restart the multiplication
//   ld_r     capture accumulator into p_out
//   a_in     multiplier operand A   (WIDTH+2 bits, < 2M)
//   b_in     multiplicand operand B (WIDTH+2 bits, < 2M)
//   m_in     odd modulus M          (WIDTH bits)
//   p_out    registered result      (WIDTH+2 bits)
//   busy     iterations in progress
//   done     WIDTH+2 iterations complete, accumulator valid
module mmm_serial_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic [WIDTH+1:0] a_in,
  input  logic [WIDTH+1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH+1:0] p_out,
  output logic             busy,
  output logic             done
);

  localparam int W2 = WIDTH + 2;
  localparam int W3 = WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 3);
  localparam logic [CW-1:0] LAST_ITER = CW'(W2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W3-1:0] acc_q, acc_d;
  logic [W2-1:0] a_sr_q, a_sr_d;
  logic [W2-1:0] b_reg_q, b_reg_d;
  logic [WIDTH-1:0] m_reg_q, m_reg_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [W2-1:0] p_out_q, p_out_d;

  logic          ai;
  logic          q;
  logic [W3-1:0] sum;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      a_sr_q    <= '0;
      b_reg_q   <= '0;
      m_reg_q   <= '0;
      counter_q <= '0;
      p_out_q   <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_sr_q    <= a_sr_d;
      b_reg_q   <= b_reg_d;
      m_reg_q   <= m_reg_d;
      counter_q <= counter_d;
      p_out_q   <= p_out_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!rst_mmm) begin
      state_d = S_IDLE;
    end else if (ld_a) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && counter_q == LAST_ITER) begin
      state_d = S_DONE;
    end
  end

  // One Montgomery step: q is chosen so the sum is even, so the shift
  // divides exactly by two.
  assign ai  = a_sr_q[0];
  assign q   = acc_q[0] ^ (ai & b_reg_q[0]);
  assign sum = acc_q + (ai ? W3'(b_reg_q) : '0) + (q ? W3'(m_reg_q) : '0);

  always_comb begin
    acc_d     = acc_q;
    a_sr_d    = a_sr_q;
    b_reg_d   = b_reg_q;
    m_reg_d   = m_reg_q;
    counter_d = counter_q;
    if (!rst_mmm) begin
      acc_d     = '0;
      a_sr_d    = '0;
      b_reg_d   = '0;
      m_reg_d   = '0;
      counter_d = '0;
    end else if (ld_a) begin
      acc_d     = '0;
      a_sr_d    = a_in;
      b_reg_d   = b_in;
      m_reg_d   = m_in;
      counter_d = '0;
    end else if (state_q == S_RUN) begin
      acc_d     = sum >> 1;
      a_sr_d    = a_sr_q >> 1;
      counter_d = counter_q + CW'(1);
    end
  end

  // Capture always sees the pre-edge accumulator, regardless of rst_mmm/ld_a
  always_comb begin
    p_out_d = p_out_q;
    if (ld_r) begin
      p_out_d = acc_q[W2-1:0];
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign p_out = p_out_q;

endmodule

// File: tb/tb_mmm_serial_core.sv
// tb/tb_mmm_serial_core.sv - randomized self-checking bench for mmm_serial_core
module tb_mmm_serial_core;

  localparam int WIDTH = 8;
  localparam int W2    = WIDTH + 2;
  localparam longint R = longint'(1) << W2;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          ena = 1'b1;
  logic          rst_mmm = 1'b1;
  logic          ld_a = 1'b0;
  logic          ld_r = 1'b0;
  logic [W2-1:0] a_in = '0;
  logic [W2-1:0] b_in = '0;
  logic [WIDTH-1:0] m_in = '0;
  logic [W2-1:0] p_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  mmm_serial_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .ld_r    (ld_r),
    .a_in    (a_in),
    .b_in    (b_in),
    .m_in    (m_in),
    .p_out   (p_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Closed form of the bit-serial result: P*R = A*B + Q*M with
  // Q = -A*B*M^-1 mod R, hence P = (A*B + Q*M) / R.
  function automatic longint mont_ref(input longint a, input longint b, input longint m);
    longint minv;
    longint qv;
    minv = 0;
    for (longint x = 1; x < R; x += 2) begin
      if (((x * m) % R) == 1) minv = x;
    end
    qv = (R - ((a * b % R) * minv % R)) % R;
    return (a * b + qv * m) / R;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input longint a, input longint b, input longint m);
    a_in = W2'(a);
    b_in = W2'(b);
    m_in = WIDTH'(m);
    ld_a = 1'b1;
    step();
    ld_a = 1'b0;
  endtask

  // Cycles from the ld_a edge until done, bounded
  task automatic wait_done(output int t);
    t = 0;
    while (!done && t < 40) begin
      step();
      t++;
    end
  endtask

  task automatic capture();
    ld_r = 1'b1;
    step();
    ld_r = 1'b0;
  endtask

  initial begin
    int t;
    int n;
    longint a, b, m, e;

    // Reset
    rstb = 1'b0;
    step();
    step();
    check("reset_p_out", p_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rstb = 1'b1;
    step();

    // Directed: 2^10 mod 239 times 100
    start(68, 100, 239);
    check("t1_busy_after_ld", busy, 1);
    n = 0;
    while (busy && n < 40) begin
      check("t1_no_done_while_busy", done, 0);
      step();
      n++;
    end
    check("t1_busy_cycles", n, 10);
    check("t1_done", done, 1);
    capture();
    check("t1_p_out", p_out, 100);
    check("t1_done_holds", done, 1);

    start(1, 1, 239);
    wait_done(t);
    check("t2_latency", t, 10);
    capture();
    check("t2_p_out", p_out, 116);

    start(0, 477, 239);
    wait_done(t);
    capture();
    check("t3_p_out", p_out, 0);

    // ena=0 in DONE: ld_r must not capture
    ena = 1'b0;
    ld_r = 1'b1;
    start(5, 5, 239);
    ld_r = 1'b0;
    ena = 1'b1;
    check("ena_low_p_out_hold", p_out, 0);
    check("ena_low_done_hold", done, 1);

    // Randomized legal operands
    for (int i = 0; i < 200; i++) begin
      m = longint'($urandom_range(1, 127)) * 2 + 1;
      a = longint'($urandom_range(0, 32'(2 * m - 1)));
      b = longint'($urandom_range(0, 32'(2 * m - 1)));
      e = mont_ref(a, b, m);
      start(a, b, m);
      wait_done(t);
      capture();
      check($sformatf("rand%0d_p_out", i), p_out, e);
      check($sformatf("rand%0d_lt_2m", i), longint'(p_out) < 2 * m, 1);
    end

    // ena freeze after 4 iterations
    start(68, 100, 239);
    for (int i = 0; i < 4; i++) step();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("freeze_busy", busy, 1);
    check("freeze_counter", dut.counter_q, 4);
    ena = 1'b1;
    t = 7;
    while (!done && t < 40) begin
      step();
      t++;
    end
    check("freeze_latency", t, 13);
    capture();
    check("freeze_p_out", p_out, 100);

    // rst_mmm abort at iteration 5
    start(77, 200, 239);
    for (int i = 0; i < 5; i++) step();
    rst_mmm = 1'b0;
    step();
    rst_mmm = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_counter", dut.counter_q, 0);
    check("abort_p_out", p_out, 100);
    step();
    check("abort_stays_idle", busy, 0);
    start(1, 1, 239);
    wait_done(t);
    check("abort_rerun_latency", t, 10);
    capture();
    check("abort_rerun_p_out", p_out, 116);

    // ld_a together with ld_r in DONE
    start(68, 100, 239);
    wait_done(t);
    a_in = 1;
    b_in = 1;
    ld_a = 1'b1;
    ld_r = 1'b1;
    step();
    ld_a = 1'b0;
    ld_r = 1'b0;
    check("ldar_p_out_old", p_out, 100);
    check("ldar_acc_cleared", dut.acc_q, 0);
    check("ldar_busy", busy, 1);
    check("ldar_done", done, 0);
    wait_done(t);
    check("ldar_latency", t, 10);
    capture();
    check("ldar_new_p_out", p_out, 116);

    // rstb mid-run
    start(68, 100, 239);
    for (int i = 0; i < 3; i++) step();
    rstb = 1'b0;
    step();
    check("rstb_mid_p_out", p_out, 0);
    check("rstb_mid_busy", busy, 0);
    check("rstb_mid_done", done, 0);
    rstb = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmm_serial_core.md
Name: mmm_serial_core

Overview:
- Bit-serial radix-2 Montgomery modular multiplier: the datapath end of the RSA control interface. The exponentiation control FSM drives rst_mmm, ld_a and ld_r; this block executes them.
- Computes P = A·B·2^-(WIDTH+2) mod M. There is no final subtraction, so the result is < 2M.
- Runs one iteration per enabled clock and captures the result into a registered output on command.
- Sits between the operand muxes (sel1/sel2-driven) and the result/lock registers of the RSA top.

Parameters:
- WIDTH, 8, bit width of modulus M. Operands and result are WIDTH+2 bits. One multiplication takes WIDTH+2 iterations.

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  reset, synchronous, active-low
- ena  input  1  clock enable; when 0, all state holds
- rst_mmm  input  1  synchronous active-low clear of multiplier state (acc, a_sr, b_reg, m_reg, counter, done); does not clear p_out
- ld_a  input  1  load operands and restart the multiplication
- ld_r  input  1  capture accumulator into p_out
- a_in  input  WIDTH+2  multiplier operand A; must be < 2M
- b_in  input  WIDTH+2  multiplicand operand B; must be < 2M
- m_in  input  WIDTH  modulus M; must be odd
- p_out  output  WIDTH+2  registered result
- busy  output  1  iterations in progress
- done  output  1  WIDTH+2 iterations complete; acc is valid

Behaviour:
- Reset (rstb=0 at a rising edge): acc, a_sr, b_reg, m_reg, counter, p_out = 0; done=0; busy=0. rstb overrides every other input, including ena.
- When ena=0, nothing changes.
- Internal state: acc (WIDTH+3 bits pre-shift), a_sr (WIDTH+2), b_reg (WIDTH+2), m_reg (WIDTH), counter ($clog2(WIDTH+3) bits), done.
- States (implicit or explicit FSM):
  - IDLE: counter=0, done=0, not loaded.
  - RUN: 0 ≤ counter < WIDTH+2, loaded.
  - DONE: counter = WIDTH+2, done=1.
- Priority of the multiplier-state updates when ena=1:
  1. rst_mmm=0 → clear acc, a_sr, b_reg, m_reg, counter, done; go to IDLE.
  2. Else ld_a=1 → a_sr←a_in, b_reg←b_in, m_reg←m_in, acc←0, counter←0, done←0; go to RUN. Holding ld_a=1 over several cycles keeps reloading, so no iteration runs.
  3. Else in RUN, one iteration per cycle:
     - ai = a_sr[0]
     - q = acc[0] XOR (ai AND b_reg[0])
     - acc ← (acc + ai·b_reg + q·m_reg) >> 1, with the sum computed at WIDTH+3 bits (no overflow for legal operands)
     - a_sr ← a_sr >> 1; counter ← counter+1
     - When counter becomes WIDTH+2 → DONE; done=1 on the following cycle.
  4. In DONE, acc holds and done stays 1 until the next ld_a or rst_mmm=0.
- busy = RUN state (registered-state decode). busy and done are never both 1.
- ld_r=1 with ena=1: p_out ← acc[WIDTH+1:0] at the next edge.
  - ld_r is honoured in any state and independently of rst_mmm and ld_a.
  - It always samples the pre-edge acc. Simultaneous ld_a/rst_mmm=0 clearing acc does not affect that capture.
- Latency: ld_a cycle, then WIDTH+2 iteration cycles, then done=1. p_out is valid one cycle after ld_r is asserted in DONE. Total for WIDTH=8: 1 + 10 cycles to done.
- Illegal inputs (even M, operands ≥ 2M): result undefined, but no X propagation. Counter and FSM behaviour are unchanged.
- rst_mmm=0 mid-RUN aborts at the next edge: counter=0, done=0, busy=0.
- ena=0 mid-RUN freezes counter and acc exactly; the run resumes without loss when ena returns to 1.

Test Plan:
- WIDTH=8, M=239, A=68 (=2^10 mod M), B=100; pulse ld_a 1 cycle → busy for 10 cycles, then done=1; ld_r → p_out=100.
- M=239, A=1, B=1 → p_out=116 (=2^-10 mod 239). A=0, B=477 → p_out=0.
- Random legal A, B < 478, M odd, 200 runs → p_out ≡ A·B·2^-10 mod M and p_out < 2M, checked against a reference model.
- Run A=68, B=100; drop ena for 3 cycles at iteration 4 → done is delayed exactly 3 cycles; p_out=100.
- rst_mmm=0 at iteration 5 → next cycle busy=0, done=0, counter=0; p_out unchanged. A subsequent fresh ld_a run gives the correct result.
- ld_a and ld_r asserted together in DONE → p_out gets the old result, acc clears, new run starts. rstb=0 mid-run → all outputs 0 next edge.
